// File: rtl/rect_plotter.sv
// rect_plotter: rasterises a clipped outline or filled rectangle into vga_adapter plot strobes,
// one scan step per cycle plus PACE idle cycles after every plotted pixel.
module rect_plotter #(
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int COLOUR_W = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int PACE = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                mode,
   input  logic [X_W-1:0]      x0,
   input  logic [Y_W-1:0]      y0,
   input  logic [X_W-1:0]      w,
   input  logic [Y_W-1:0]      h,
   input  logic [COLOUR_W-1:0] colour_in,
   output logic                busy,
   output logic                done,
   output logic                plot,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour
);
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   localparam logic [19:0] PACE_C = 20'(PACE);
   localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);
   state_t state, nxt;
   logic [X_W-1:0] lx0, lw, c;
   logic [Y_W-1:0] ly0, lh, r;
   logic [COLOUR_W-1:0] lcol;
   logic lmode;
   logic [19:0] pc;
   logic [X_W:0] xs;
   logic [Y_W:0] ys;
   logic visible, step_end, row_end, last, interior;
   // one extra bit so pixels past the right/bottom edge clip instead of wrapping
   assign xs = {1'b0, lx0} + {1'b0, c};
   assign ys = {1'b0, ly0} + {1'b0, r};
   assign visible = xs < SW && ys < SH;
   assign step_end = !visible || pc == PACE_C;
   assign row_end = c == lw - 1'b1;
   assign last = row_end && r == lh - 1'b1;
   assign interior = !lmode && r != '0 && r != lh - 1'b1;
   always_ff @(posedge clk)
      state <= !reset ? IDLE : nxt;
   always_comb begin
      nxt = state;
      if (state == IDLE)
         nxt = start ? ((w == '0 || h == '0) ? DONE : DRAW) : IDLE;
      else if (state == DRAW)
         nxt = step_end && last ? DONE : DRAW;
      else
         nxt = IDLE;
   end
   always_comb begin
      busy = state == DRAW;
      done = state == DONE;
      plot = busy && visible && pc == '0;
      x = busy ? xs[X_W-1:0] : '0;
      y = busy ? ys[Y_W-1:0] : '0;
      colour = busy ? lcol : '0;
   end
   always_ff @(posedge clk)
      if (!reset) begin
         lx0 <= '0;
         ly0 <= '0;
         lw <= '0;
         lh <= '0;
         lcol <= '0;
         lmode <= 1'b0;
         r <= '0;
         c <= '0;
         pc <= '0;
      end else if (state == IDLE && start) begin
         lx0 <= x0;
         ly0 <= y0;
         lw <= w;
         lh <= h;
         lcol <= colour_in;
         lmode <= mode;
         r <= '0;
         c <= '0;
         pc <= '0;
      end else if (state == DRAW) begin
         if (!step_end)
            pc <= pc + 1'b1;
         else begin
            // outline interior rows jump straight from the left edge to the right edge
            pc <= '0;
            c <= row_end ? '0 : interior ? lw - 1'b1 : c + 1'b1;
            r <= row_end ? r + 1'b1 : r;
         end
      end
endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: runs identical requests into a PACE=0 and a PACE=3 plotter; expected pixels
// and done cycles come from a border/clip model and are checked by a decoupled monitor.
module tb_rect_plotter;
   typedef struct {int x; int y; int col; int cyc;} pix_t;
   logic clk = 0, reset = 0, start = 0, mode = 0, zchk = 0;
   logic [7:0] x0 = 0, w = 0;
   logic [6:0] y0 = 0, h = 0;
   logic [2:0] colour_in = 0;
   logic busy[2], done[2], plot[2];
   logic [7:0] x[2];
   logic [6:0] y[2];
   logic [2:0] colour[2];
   pix_t pq[2][$];
   int dq[2][$];
   int total = 0, bad = 0, cyc = 0;

   rect_plotter #(.PACE(0)) dut0 (.clk(clk), .reset(reset), .start(start), .mode(mode), .x0(x0),
      .y0(y0), .w(w), .h(h), .colour_in(colour_in), .busy(busy[0]), .done(done[0]),
      .plot(plot[0]), .x(x[0]), .y(y[0]), .colour(colour[0]));
   rect_plotter #(.PACE(3)) dut3 (.clk(clk), .reset(reset), .start(start), .mode(mode), .x0(x0),
      .y0(y0), .w(w), .h(h), .colour_in(colour_in), .busy(busy[1]), .done(done[1]),
      .plot(plot[1]), .x(x[1]), .y(y[1]), .colour(colour[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      pix_t e;
      int dc;
      for (int d = 0; d < 2; d++) begin
         if (zchk) begin
            total++;
            if (busy[d] || done[d] || plot[d] || x[d] != 0 || y[d] != 0 || colour[d] != 0) begin
               bad++;
               $display("FAIL zero[%0d] cyc %0d: busy=%b done=%b plot=%b x=%0d y=%0d colour=%0d, want all 0",
                  d, cyc, busy[d], done[d], plot[d], x[d], y[d], colour[d]);
            end
         end
         if (plot[d]) begin
            total++;
            if (pq[d].size() == 0) begin
               bad++;
               $display("FAIL pixel[%0d] cyc %0d: unexpected plot at (%0d,%0d)", d, cyc, x[d], y[d]);
            end else begin
               e = pq[d].pop_front();
               if (int'(x[d]) != e.x || int'(y[d]) != e.y || int'(colour[d]) != e.col || cyc != e.cyc || !busy[d]) begin
                  bad++;
                  $display("FAIL pixel[%0d]: got (%0d,%0d) col %0d cyc %0d busy %b, want (%0d,%0d) col %0d cyc %0d busy 1",
                     d, x[d], y[d], colour[d], cyc, busy[d], e.x, e.y, e.col, e.cyc);
               end
            end
         end else if (pq[d].size() != 0 && pq[d][0].cyc <= cyc) begin
            total++;
            bad++;
            e = pq[d].pop_front();
            $display("FAIL pixel[%0d]: no plot at cyc %0d, want (%0d,%0d)", d, e.cyc, e.x, e.y);
         end
         if (done[d]) begin
            total++;
            if (dq[d].size() == 0) begin
               bad++;
               $display("FAIL done[%0d] cyc %0d: unexpected done pulse", d, cyc);
            end else begin
               dc = dq[d].pop_front();
               if (cyc != dc || busy[d] || plot[d]) begin
                  bad++;
                  $display("FAIL done[%0d]: cyc %0d busy %b plot %b, want cyc %0d busy 0 plot 0",
                     d, cyc, busy[d], plot[d], dc);
               end
            end
         end else if (dq[d].size() != 0 && dq[d][0] <= cyc) begin
            total++;
            bad++;
            dc = dq[d].pop_front();
            $display("FAIL done[%0d]: no done pulse at cyc %0d", d, dc);
         end
      end
   end

   // Raster walk over the rectangle keeping border pixels (or all of them when filled);
   // events at or after cut are dropped because a reset aborts the draw there.
   function automatic int build(int d, int pace, int n, int cut, logic md, int ax, int ay, int aw, int ah, int col);
      int t = 0;
      for (int r = 0; r < ah; r++)
         for (int c = 0; c < aw; c++) begin
            if (!(md || r == 0 || r == ah - 1 || c == 0 || c == aw - 1)) continue;
            if (ax + c < 160 && ay + r < 120) begin
               if (n + t < cut) pq[d].push_back('{ax + c, ay + r, col, n + t});
               t += 1 + pace;
            end else
               t += 1;
         end
      if (n + t < cut) dq[d].push_back(n + t);
      return n + t;
   endfunction

   task automatic draw(input logic md, input int ax, ay, aw, ah, col, input int cut, input bit poke);
      int n, e0, e1;
      @(negedge clk);
      mode = md; x0 = 8'(ax); y0 = 7'(ay); w = 8'(aw); h = 7'(ah); colour_in = 3'(col);
      start = 1;
      n = cyc + 1;
      e0 = build(0, 0, n, n + cut, md, ax, ay, aw, ah, col);
      e1 = build(1, 3, n, n + cut, md, ax, ay, aw, ah, col);
      @(negedge clk);
      start = 0;
      x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
      colour_in = 3'($urandom); mode = 1'($urandom);
      if (poke) begin
         @(negedge clk);
         start = 1;
         x0 = 8'(ax + 50);
         @(negedge clk);
         start = 0;
      end
      if (cut < 1000) begin
         while (cyc < n + cut - 1) @(negedge clk);
         reset = 0;
         @(posedge clk);
         #1 zchk = 1;
         reset = 1;
         @(negedge clk);
         #1 zchk = 0;
      end else
         while (cyc <= (e0 > e1 ? e0 : e1)) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 zchk = 1;
      @(negedge clk);
      #1 zchk = 0;
      reset = 1;
      draw(1, 10, 20, 3, 2, 5, 1 << 30, 0);
      draw(0, 10, 20, 4, 3, 6, 1 << 30, 0);
      draw(1, 158, 119, 4, 2, 7, 1 << 30, 0);
      draw(1, 0, 0, 2, 1, 3, 1 << 30, 0);
      draw(1, 30, 40, 0, 5, 1, 1 << 30, 0);
      draw(1, 50, 60, 3, 2, 2, 1 << 30, 1);
      draw(1, 70, 80, 3, 2, 4, 3, 0);
      draw(1, 70, 80, 3, 2, 4, 1 << 30, 0);
      draw(0, 5, 5, 1, 4, 2, 1 << 30, 0);
      draw(0, 100, 50, 6, 1, 1, 1 << 30, 0);
      for (int i = 0; i < 30; i++)
         draw(1'($urandom), (i % 2) ? $urandom_range(150, 170) : $urandom_range(0, 150),
            (i % 3 == 0) ? $urandom_range(112, 127) : $urandom_range(0, 110),
            $urandom_range(0, 8), $urandom_range(0, 6), $urandom_range(0, 7), 1 << 30, 0);
      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
